// File: rtl/tron_isa_pkg.sv
// Shared ISA constants, instruction classes and sequencer state encoding.
// Latency: none. This file holds declarations only.
// Backpressure: none.
package tron_isa_pkg;

    // Major opcode field instr[15:12]
    localparam logic [3:0] OP_RR    = 4'h0;  // register-register ALU group (holds CMP)
    localparam logic [3:0] OP_EXT   = 4'h4;  // LOAD/STOR/JAL/Jcond group, selected by opext
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_BCOND = 4'hC;

    // Extended opcode field instr[7:4]
    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_CMP   = 4'hB;
    localparam logic [3:0] EXT_JCOND = 4'hC;

    // Condition codes carried on flagOp
    localparam logic [3:0] COND_EQ  = 4'h0;
    localparam logic [3:0] COND_NE  = 4'h1;
    localparam logic [3:0] COND_CS  = 4'h2;
    localparam logic [3:0] COND_CC  = 4'h3;
    localparam logic [3:0] COND_HI  = 4'h4;
    localparam logic [3:0] COND_LS  = 4'h5;
    localparam logic [3:0] COND_GT  = 4'h6;
    localparam logic [3:0] COND_LE  = 4'h7;
    localparam logic [3:0] COND_FS  = 4'h8;
    localparam logic [3:0] COND_FC  = 4'h9;
    localparam logic [3:0] COND_LO  = 4'hA;
    localparam logic [3:0] COND_HS  = 4'hB;
    localparam logic [3:0] COND_LT  = 4'hC;
    localparam logic [3:0] COND_GE  = 4'hD;
    localparam logic [3:0] COND_UC  = 4'hE;
    localparam logic [3:0] COND_JAL = 4'hF;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_CMP,
        CLS_LOAD,
        CLS_STOR,
        CLS_BCOND,
        CLS_JCOND,
        CLS_JAL
    } instr_class_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_PCUPD
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: class, condition field, sign-extended displacement.
// Latency: zero cycles (pure combinational). Backpressure: none.
// Ports: instr (latched instruction) -> cls, cond (instr[11:8]), illegal (Bcond cond=F),
//        disp (instr[DISP_BITS-1:0] sign-extended to WIDTH).
import tron_isa_pkg::*;

module instr_decoder #(
    parameter int WIDTH     = 16,
    parameter int DISP_BITS = 8
) (
    input  logic [15:0]      instr,
    output instr_class_t     cls,
    output logic [3:0]       cond,
    output logic             illegal,
    output logic [WIDTH-1:0] disp
);

    logic [3:0] op;
    logic [3:0] opext;

    assign op    = instr[15:12];
    assign opext = instr[7:4];
    assign cond  = instr[11:8];
    assign disp  = {{(WIDTH-DISP_BITS){instr[DISP_BITS-1]}}, instr[DISP_BITS-1:0]};

    always_comb begin
        cls     = CLS_ALU;
        illegal = 1'b0;
        if (op == OP_BCOND) begin
            cls = CLS_BCOND;
            // cond=F has no branch meaning; the sequencer treats it as a plain PC+1.
            illegal = (cond == COND_JAL);
        end else if (op == OP_EXT) begin
            case (opext)
                EXT_LOAD:  cls = CLS_LOAD;
                EXT_STOR:  cls = CLS_STOR;
                EXT_JAL:   cls = CLS_JAL;
                EXT_JCOND: cls = CLS_JCOND;
                default:   cls = CLS_ALU;
            endcase
        end else if (op == OP_CMPI || (op == OP_RR && opext == EXT_CMP)) begin
            cls = CLS_CMP;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> {MEM} -> PCUPD, one PC strobe per instruction.
// Latency: 4 cycles per instruction, 5+ with MEM; PC strobe in the last (PCUPD) cycle.
// Backpressure: only via memReady in MEM when SEQ_MEM_WAIT_EN is defined; otherwise none.
// Ports: clk/reset (async active-low); instrIn sampled in FETCH; rsrcData sampled in DECODE;
//        pcAdd/pcBranch/pcJump strobes; flagOp/immediate/rTarget held from DECODE to next DECODE;
//        instrReg latched instruction; regWrite/flagWrite/memWrite/linkWrite enables.
// Option macro SEQ_MEM_WAIT_EN: MEM waits for memReady; undefined means MEM lasts one cycle.
import tron_isa_pkg::*;

module instr_sequencer #(
    parameter int WIDTH     = 16,
    parameter int DISP_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      instrIn,
    input  logic [WIDTH-1:0] rsrcData,
    input  logic             memReady,
    output logic             pcAdd,
    output logic             pcBranch,
    output logic             pcJump,
    output logic [3:0]       flagOp,
    output logic [WIDTH-1:0] immediate,
    output logic [WIDTH-1:0] rTarget,
    output logic [15:0]      instrReg,
    output logic             regWrite,
    output logic             flagWrite,
    output logic             memWrite,
    output logic             linkWrite
);

    state_t           state;
    state_t           state_nxt;
    instr_class_t     cls;
    logic [3:0]       cond;
    logic             illegal;
    logic [WIDTH-1:0] disp;
    logic             mem_done;
    logic             is_branch;
    logic [3:0]       flag_nxt;
    logic [WIDTH-1:0] imm_nxt;
    logic [WIDTH-1:0] rt_nxt;

    instr_decoder #(
        .WIDTH     (WIDTH),
        .DISP_BITS (DISP_BITS)
    ) u_decoder (
        .instr   (instrReg),
        .cls     (cls),
        .cond    (cond),
        .illegal (illegal),
        .disp    (disp)
    );

`ifdef SEQ_MEM_WAIT_EN
    assign mem_done = memReady;
`else
    // MEM is always a single cycle; memReady has no effect on the result.
    assign mem_done = 1'b1 | memReady;
`endif

    assign is_branch = (cls == CLS_BCOND) && !illegal;

    // Values captured at the end of DECODE and held until the next DECODE.
    always_comb begin
        flag_nxt = COND_UC;
        imm_nxt  = '0;
        rt_nxt   = '0;
        case (cls)
            CLS_BCOND: begin
                if (!illegal) begin
                    flag_nxt = cond;
                    imm_nxt  = disp;
                end
            end
            CLS_JCOND: begin
                flag_nxt = cond;
                imm_nxt  = rsrcData;
            end
            CLS_JAL: begin
                flag_nxt = COND_JAL;
                rt_nxt   = rsrcData;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_FETCH;
            instrReg  <= '0;
            flagOp    <= COND_UC;
            immediate <= '0;
            rTarget   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH) begin
                instrReg <= instrIn;
            end
            if (state == ST_DECODE) begin
                flagOp    <= flag_nxt;
                immediate <= imm_nxt;
                rTarget   <= rt_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pcAdd     = 1'b0;
        pcBranch  = 1'b0;
        pcJump    = 1'b0;
        regWrite  = 1'b0;
        flagWrite = 1'b0;
        memWrite  = 1'b0;
        linkWrite = 1'b0;
        case (state)
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                regWrite  = (cls == CLS_ALU);
                flagWrite = (cls == CLS_ALU) || (cls == CLS_CMP);
                linkWrite = (cls == CLS_JAL);
                if (cls == CLS_LOAD || cls == CLS_STOR) begin
                    state_nxt = ST_MEM;
                end else begin
                    state_nxt = ST_PCUPD;
                end
            end
            ST_MEM: begin
                memWrite = (cls == CLS_STOR);
                // Load data is written back in the last MEM cycle only.
                if (mem_done) begin
                    regWrite  = (cls == CLS_LOAD);
                    state_nxt = ST_PCUPD;
                end
            end
            ST_PCUPD: begin
                state_nxt = ST_FETCH;
                if (is_branch) begin
                    pcBranch = 1'b1;
                end else if (cls == CLS_JCOND || cls == CLS_JAL) begin
                    pcJump = 1'b1;
                end else begin
                    pcAdd = 1'b1;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer with an instruction-level reference model.
// Latency: n/a. Backpressure: memReady driven by the bench during MEM.
// Honours SEQ_MEM_WAIT_EN if defined for the build.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instrIn;
    logic [15:0] rsrcData;
    logic        memReady;
    logic        pcAdd, pcBranch, pcJump;
    logic [3:0]  flagOp;
    logic [15:0] immediate, rTarget, instrReg;
    logic        regWrite, flagWrite, memWrite, linkWrite;

    instr_sequencer #(.WIDTH(16), .DISP_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .instrIn   (instrIn),
        .rsrcData  (rsrcData),
        .memReady  (memReady),
        .pcAdd     (pcAdd),
        .pcBranch  (pcBranch),
        .pcJump    (pcJump),
        .flagOp    (flagOp),
        .immediate (immediate),
        .rTarget   (rTarget),
        .instrReg  (instrReg),
        .regWrite  (regWrite),
        .flagWrite (flagWrite),
        .memWrite  (memWrite),
        .linkWrite (linkWrite)
    );

    always #5 clk = ~clk;

    // Instruction kinds as the bench sees them
    localparam int K_ALU = 0, K_CMP = 1, K_LOAD = 2, K_STOR = 3;
    localparam int K_BC = 4, K_JC = 5, K_JAL = 6, K_ILLB = 7;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle; strobe vector order:
    // {pcAdd, pcBranch, pcJump, regWrite, flagWrite, memWrite, linkWrite}
    logic [6:0]  e_strb;
    logic [3:0]  e_flag;
    logic [15:0] e_imm, e_rt, e_ireg;
    logic [6:0]  act_strb;

    // Model of the held registered outputs
    logic [3:0]  m_flag;
    logic [15:0] m_imm, m_rt, m_ireg;

    // Strobe activity counters
    int n_pa = 0, n_pb = 0, n_pj = 0, n_rw = 0, n_fw = 0, n_mw = 0, n_lw = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            act_strb = {pcAdd, pcBranch, pcJump, regWrite, flagWrite, memWrite, linkWrite};
            chk("strobes", {25'd0, act_strb}, {25'd0, e_strb});
            chk("flagOp", {28'd0, flagOp}, {28'd0, e_flag});
            chk("immediate", {16'd0, immediate}, {16'd0, e_imm});
            chk("rTarget", {16'd0, rTarget}, {16'd0, e_rt});
            chk("instrReg", {16'd0, instrReg}, {16'd0, e_ireg});
            n_pa += int'(pcAdd);
            n_pb += int'(pcBranch);
            n_pj += int'(pcJump);
            n_rw += int'(regWrite);
            n_fw += int'(flagWrite);
            n_mw += int'(memWrite);
            n_lw += int'(linkWrite);
        end
    end

    function automatic int kind(input logic [15:0] ins);
        logic [3:0] op, ext;
        op  = ins[15:12];
        ext = ins[7:4];
        if (op == 4'hC) return (ins[11:8] == 4'hF) ? K_ILLB : K_BC;
        if (op == 4'h4) begin
            if (ext == 4'h0) return K_LOAD;
            if (ext == 4'h4) return K_STOR;
            if (ext == 4'h8) return K_JAL;
            if (ext == 4'hC) return K_JC;
            return K_ALU;
        end
        if (op == 4'hB || (op == 4'h0 && ext == 4'hB)) return K_CMP;
        return K_ALU;
    endfunction

    function automatic logic [6:0] mk(input bit pa, pb, pj, rw, fw, mw, lw);
        return {pa, pb, pj, rw, fw, mw, lw};
    endfunction

    function automatic logic [15:0] rnd_instr();
        logic [15:0] x;
        x = 16'($urandom);
        case ($urandom % 8)
            0: begin x[15:12] = 4'h4; x[7:4] = 4'h0; end
            1: begin x[15:12] = 4'h4; x[7:4] = 4'h4; end
            2: begin x[15:12] = 4'h4; x[7:4] = 4'h8; end
            3: begin x[15:12] = 4'h4; x[7:4] = 4'hC; end
            4: x[15:12] = 4'hC;
            5: begin x[15:12] = 4'h0; x[7:4] = 4'hB; end
            6: x[15:12] = 4'hB;
            default: ;
        endcase
        return x;
    endfunction

    task automatic model_reset();
        m_ireg = 16'h0000;
        m_flag = 4'hE;
        m_imm  = 16'h0000;
        m_rt   = 16'h0000;
    endtask

    // Publish this cycle's expectations, then advance to 1 time unit after the next edge.
    task automatic step(input logic [6:0] s);
        e_strb = s;
        e_flag = m_flag;
        e_imm  = m_imm;
        e_rt   = m_rt;
        e_ireg = m_ireg;
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from its FETCH cycle through PCUPD.
    // abort: for LOAD/STOR, pull reset low at the start of MEM and release two cycles later.
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] rs,
                             input int wait_n, input bit abort);
        int k;
        bit mem_op;
        k = kind(ins);
        mem_op = (k == K_LOAD) || (k == K_STOR);

        instrIn  = ins;
        rsrcData = 16'($urandom);
        memReady = 1'($urandom);
        step(7'd0);

        m_ireg   = ins;
        instrIn  = 16'($urandom);
        rsrcData = rs;
        memReady = 1'($urandom);
        step(7'd0);

        m_flag = 4'hE;
        m_imm  = 16'h0000;
        m_rt   = 16'h0000;
        if (k == K_BC) begin
            m_flag = ins[11:8];
            m_imm  = 16'(signed'(ins[7:0]));
        end else if (k == K_JC) begin
            m_flag = ins[11:8];
            m_imm  = rs;
        end else if (k == K_JAL) begin
            m_flag = 4'hF;
            m_rt   = rs;
        end
        rsrcData = 16'($urandom);
        memReady = 1'($urandom);
        step(mk(0, 0, 0, k == K_ALU, k == K_ALU || k == K_CMP, 0, k == K_JAL));

        if (mem_op) begin
            if (abort) begin
                reset = 1'b0;
                model_reset();
                step(7'd0);
                step(7'd0);
                reset = 1'b1;
                return;
            end
`ifdef SEQ_MEM_WAIT_EN
            for (int i = 0; i < wait_n; i++) begin
                memReady = 1'b0;
                step(mk(0, 0, 0, 0, 0, k == K_STOR, 0));
            end
            memReady = 1'b1;
`else
            memReady = 1'($urandom);
`endif
            step(mk(0, 0, 0, k == K_LOAD, 0, k == K_STOR, 0));
        end

        memReady = 1'($urandom);
        step(mk(!(k == K_BC || k == K_JC || k == K_JAL), k == K_BC, k == K_JC || k == K_JAL,
                0, 0, 0, 0));
    endtask

    int b_pa, b_pb, b_pj, b_rw, b_mw, b_lw;
    task automatic snap();
        b_pa = n_pa; b_pb = n_pb; b_pj = n_pj; b_rw = n_rw; b_mw = n_mw; b_lw = n_lw;
    endtask

    initial begin
        logic [15:0] ins;
        reset    = 1'b0;
        instrIn  = 16'h0000;
        rsrcData = 16'h0000;
        memReady = 1'b0;
        model_reset();
        e_strb = 7'd0;
        e_flag = m_flag;
        e_imm  = m_imm;
        e_rt   = m_rt;
        e_ireg = m_ireg;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // ADD R1,R2
        snap();
        run_instr(16'h0152, 16'h1234, 0, 0);
        chk("t1_pcadd_count", n_pa - b_pa, 1);
        chk("t1_regwrite_count", n_rw - b_rw, 1);
        chk("t1_instrReg", {16'd0, instrReg}, 32'h0152);

        // BEQ disp -2
        snap();
        run_instr(16'hC0FE, 16'h5555, 0, 0);
        chk("t2_pcbranch_count", n_pb - b_pb, 1);
        chk("t2_flagOp", {28'd0, flagOp}, 32'h0);
        chk("t2_immediate", {16'd0, immediate}, 32'hFFFE);

        // JAL R3
        snap();
        run_instr(16'h4283, 16'h0040, 0, 0);
        chk("t3_linkwrite_count", n_lw - b_lw, 1);
        chk("t3_pcjump_count", n_pj - b_pj, 1);
        chk("t3_flagOp", {28'd0, flagOp}, 32'hF);
        chk("t3_rTarget", {16'd0, rTarget}, 32'h0040);

        // STOR with memReady low for 3 MEM cycles
        snap();
        run_instr(16'h4143, 16'h0000, 3, 0);
`ifdef SEQ_MEM_WAIT_EN
        chk("t4_memwrite_cycles", n_mw - b_mw, 4);
`else
        chk("t4_memwrite_cycles", n_mw - b_mw, 1);
`endif
        chk("t4_pcadd_count", n_pa - b_pa, 1);

        // LOAD aborted by reset in MEM
        snap();
        run_instr(16'h4103, 16'h0000, 2, 1);
        chk("t5_regwrite_count", n_rw - b_rw, 0);
        chk("t5_pc_strobes", (n_pa - b_pa) + (n_pb - b_pb) + (n_pj - b_pj), 0);
        chk("t5_instrReg", {16'd0, instrReg}, 32'h0);

        // Illegal Bcond
        snap();
        run_instr(16'hCF05, 16'h0000, 0, 0);
        chk("t6_pcadd_count", n_pa - b_pa, 1);
        chk("t6_pcbranch_count", n_pb - b_pb, 0);
        chk("t6_flagOp", {28'd0, flagOp}, 32'hE);

        // Displacement extremes
        run_instr(16'hC180, 16'h0000, 0, 0);
        chk("disp_80", {16'd0, immediate}, 32'hFF80);
        run_instr(16'hC27F, 16'h0000, 0, 0);
        chk("disp_7F", {16'd0, immediate}, 32'h007F);

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            ins = rnd_instr();
            run_instr(ins, 16'($urandom), int'($urandom % 4), ($urandom % 12) == 0);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
